// File: rtl/conv_encoder_puncture_pkg.sv
// Shared constants for the 802.11a K=7 convolutional encoder and its puncturer:
// rate codes, generator polynomials, FSM encoding and puncture-pattern helpers.
package conv_encoder_puncture_pkg;

   localparam int          CONV_K  = 7;
   localparam logic [6:0]  CONV_G0 = 7'o133;
   localparam logic [6:0]  CONV_G1 = 7'o171;

   typedef enum logic [1:0] {
      RATE_1_2  = 2'b00,
      RATE_2_3  = 2'b01,
      RATE_3_4  = 2'b10,
      RATE_RSVD = 2'b11
   } rate_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EMIT_A = 2'd1;
   localparam logic [1:0] ST_EMIT_B = 2'd2;

   typedef struct packed {
      logic keep_a;
      logic keep_b;
   } keep_t;

   // The reserved code behaves exactly like rate 1/2.
   function automatic rate_e rate_norm(input logic [1:0] code);
      rate_e r;
      r = rate_e'(code);
      if (r == RATE_RSVD) begin
         r = RATE_1_2;
      end
      return r;
   endfunction

   function automatic keep_t puncture_keep(input rate_e rate, input logic [1:0] phase);
      keep_t k;
      k.keep_a = 1'b1;
      k.keep_b = 1'b1;
      case (rate)
         RATE_2_3: begin
            if (phase == 2'd1) k.keep_b = 1'b0;
         end
         RATE_3_4: begin
            if (phase == 2'd1) k.keep_b = 1'b0;
            if (phase == 2'd2) k.keep_a = 1'b0;
         end
         default: ;
      endcase
      return k;
   endfunction

   function automatic logic [1:0] phase_next(input rate_e rate, input logic [1:0] phase);
      logic [1:0] p;
      case (rate)
         RATE_2_3: p = (phase == 2'd1) ? 2'd0 : 2'd1;
         RATE_3_4: p = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
         default:  p = 2'd0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/conv_encoder_puncture_if.sv
// One-bit valid/ready stream used on both sides of the encoder.
interface conv_encoder_puncture_if;
   logic data;
   logic valid;
   logic ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conv_encoder_puncture_core.sv
// K-stage convolutional encoder core: shift register plus the two generator XOR trees.
module conv_core
   import conv_encoder_puncture_pkg::*;
#(
   parameter int             CL     = CONV_K,
   parameter logic [CL-1:0]  POLY_A = CONV_G0,
   parameter logic [CL-1:0]  POLY_B = CONV_G1
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clear,
   input  logic shift_en,
   input  logic din,
   output logic a,
   output logic b
);

   logic [CL-2:0] s_reg;
   logic [CL-1:0] window;

   // Polynomial MSB taps the current input, lower bits tap progressively older bits.
   assign window[CL-1] = din;
   generate
      for (genvar gi = 0; gi < CL-1; gi++) begin : g_window
         assign window[CL-2-gi] = s_reg[gi];
      end
   endgenerate

   assign a = ^(window & POLY_A);
   assign b = ^(window & POLY_B);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         s_reg <= '0;
      end else if (clear) begin
         s_reg <= '0;
      end else if (shift_en) begin
         s_reg <= {s_reg[CL-3:0], din};
      end
   end

endmodule

// File: rtl/conv_encoder_puncture.sv
// Rate-1/2 K=7 convolutional encoder with 2/3 and 3/4 puncturing, emitting one
// coded bit per cycle over a valid/ready stream.
module conv_encoder_puncture
   import conv_encoder_puncture_pkg::*;
#(
   parameter int            K  = CONV_K,
   parameter logic [K-1:0]  G0 = CONV_G0,
   parameter logic [K-1:0]  G1 = CONV_G1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Frame_Start,
   input  logic [1:0]            Rate,
   conv_encoder_puncture_if.slave  in_bus,
   conv_encoder_puncture_if.master out_bus
);

   logic [1:0] state_reg, state_next;
   logic       a_reg, b_reg, keep_b_reg;
   logic [1:0] phase_reg;
   rate_e      rate_reg;

   logic  core_a, core_b;
   keep_t keep;
   logic  group_last;
   logic  out_valid, in_ready;
   logic  accept, xfer;
   logic  out_bit;

   conv_core #(
      .CL     (K),
      .POLY_A (G0),
      .POLY_B (G1)
   ) u_core (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear    (Frame_Start),
      .shift_en (accept),
      .din      (in_bus.data),
      .a        (core_a),
      .b        (core_b)
   );

   assign keep = puncture_keep(rate_reg, phase_reg);

   // The group ends in EMIT_B, or in EMIT_A when B was punctured away.
   assign group_last = (state_reg == ST_EMIT_B) ||
                       ((state_reg == ST_EMIT_A) && !keep_b_reg);

   assign out_valid = (state_reg != ST_IDLE) && !Frame_Start;
   assign in_ready  = !Frame_Start &&
                      ((state_reg == ST_IDLE) || (group_last && out_bus.ready));
   assign accept    = in_bus.valid && in_ready;
   assign xfer      = out_valid && out_bus.ready;

   always_comb begin
      out_bit = 1'b0;
      case (state_reg)
         ST_EMIT_A: out_bit = a_reg;
         ST_EMIT_B: out_bit = b_reg;
         default:   out_bit = 1'b0;
      endcase
   end

   assign out_bus.data  = out_bit;
   assign out_bus.valid = out_valid;
   assign in_bus.ready  = in_ready;

   always_comb begin
      state_next = state_reg;
      if (Frame_Start) begin
         state_next = ST_IDLE;
      end else if (accept) begin
         state_next = keep.keep_a ? ST_EMIT_A : ST_EMIT_B;
      end else if (xfer) begin
         state_next = ((state_reg == ST_EMIT_A) && keep_b_reg) ? ST_EMIT_B : ST_IDLE;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg  <= ST_IDLE;
         a_reg      <= 1'b0;
         b_reg      <= 1'b0;
         keep_b_reg <= 1'b0;
         phase_reg  <= 2'd0;
         rate_reg   <= RATE_1_2;
      end else begin
         state_reg <= state_next;
         if (Frame_Start) begin
            phase_reg <= 2'd0;
            rate_reg  <= rate_norm(Rate);
         end else if (accept) begin
            a_reg      <= core_a;
            b_reg      <= core_b;
            keep_b_reg <= keep.keep_b;
            phase_reg  <= phase_next(rate_reg, phase_reg);
         end
      end
   end

endmodule

// File: tb/tb_conv_encoder_puncture.sv
// Scoreboard bench for conv_encoder_puncture: directed frames push expected coded
// bits into a queue, an independent monitor pops them on every output transfer.
module tb_conv_encoder_puncture;
   import conv_encoder_puncture_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Frame_Start = 1'b0;
   logic [1:0] Rate = 2'b00;

   conv_encoder_puncture_if in_if();
   conv_encoder_puncture_if out_if();

   conv_encoder_puncture dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Frame_Start (Frame_Start),
      .Rate        (Rate),
      .in_bus      (in_if),
      .out_bus     (out_if)
   );

   always #5 Clock = ~Clock;

   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
   logic exp_q[$];

   always @(posedge Clock) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Sole driver of downstream ready.
   initial begin
      out_if.ready = 1'b1;
      forever begin
         @(posedge Clock);
         #1;
         case (ready_mode)
            0:       out_if.ready = 1'b0;
            2:       out_if.ready = 1'($urandom_range(0, 1));
            default: out_if.ready = 1'b1;
         endcase
      end
   end

   // Monitor: scoreboard pop on each transfer, stall-stability and no-accept-while-stalled.
   initial begin
      logic prev_stall;
      logic prev_out;
      logic e;
      prev_stall = 1'b0;
      prev_out   = 1'b0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_if.valid)
               check("stall_hold", 32'(out_if.data), 32'(prev_out));
            if (out_if.valid && !out_if.ready)
               check("no_accept_while_stalled", 32'(in_if.ready), 32'd0);
            if (out_if.valid && out_if.ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: got %0b expected no output (cycle %0d)",
                           out_if.data, cycle);
               end else begin
                  e = exp_q.pop_front();
                  check("out_bit", 32'(out_if.data), 32'(e));
               end
            end
            prev_stall = out_if.valid && !out_if.ready;
            prev_out   = out_if.data;
         end
      end
   end

   task automatic pulse_frame_start(input logic [1:0] r);
      Frame_Start = 1'b1;
      Rate        = r;
      @(negedge Clock);
      check("fs_out_valid", 32'(out_if.valid), 32'd0);
      check("fs_in_ready", 32'(in_if.ready), 32'd0);
      @(posedge Clock);
      #1;
      Frame_Start = 1'b0;
      Rate        = ~r;    // must be ignored until the next Frame_Start
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge Clock);
         if (exp_q.size() == 0 && !out_if.valid) done = 1'b1;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s_drain: got %0d bits still pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge Clock);
      #1;
   endtask

   // Sends n input bits (MSB first) and queues ne expected coded bits (MSB first).
   task automatic run_frame(input string name, input bit do_fs, input logic [1:0] r,
                            input int n, input logic [63:0] din,
                            input int ne, input logic [63:0] dexp, input int span);
      int first_c, last_c;
      bit acc;
      first_c = 0;
      last_c  = 0;
      for (int i = 0; i < ne; i++) exp_q.push_back(dexp[ne-1-i]);
      if (do_fs) pulse_frame_start(r);
      for (int i = 0; i < n; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = din[n-1-i];
         acc = 1'b0;
         for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge Clock);
            acc = in_if.ready;
            if (acc) begin
               if (i == 0) first_c = cycle;
               last_c = cycle;
            end
            @(posedge Clock);
            #1;
         end
         if (!acc) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: got no In_Ready for bit %0d expected acceptance", name, i);
            break;
         end
      end
      in_if.valid = 1'b0;
      in_if.data  = 1'b0;
      if (span >= 0) check({name, "_span"}, 32'(last_c - first_c), 32'(span));
      drain(name);
   endtask

   initial begin
      in_if.valid = 1'b0;
      in_if.data  = 1'b0;

      // Reset state
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_out_valid", 32'(out_if.valid), 32'd0);
      check("rst_output", 32'(out_if.data), 32'd0);
      check("rst_in_ready", 32'(in_if.ready), 32'd1);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(posedge Clock);
      #1;

      // Rate 1/2 all zeros: 16 in, 32 out, one input every 2 cycles.
      run_frame("r12_zero", 1'b1, 2'b00, 16, 64'd0, 32, 64'd0, 30);
      // Rate 1/2 impulse: 11 01 11 11 00 10 11 00
      run_frame("r12_imp", 1'b1, 2'b00, 8, 64'b1000_0000, 16, 64'b1101_1111_0010_1100, 14);
      // Rate 3/4 impulse: 1101 1100 1100 0000
      run_frame("r34_imp", 1'b1, 2'b10, 12, 64'b1000_0000_0000, 16, 64'b1101_1100_1100_0000, 15);
      // Rate 2/3 impulse: 110 111 001 110 000
      run_frame("r23_imp", 1'b1, 2'b01, 10, 64'b10_0000_0000, 15, 64'b110_111_001_110_000, 14);
      // Reserved rate code behaves as 1/2
      run_frame("r11_imp", 1'b1, 2'b11, 8, 64'b1000_0000, 16, 64'b1101_1111_0010_1100, 14);

      // Rate 1/2 impulse under random backpressure
      ready_mode = 2;
      run_frame("r12_rand", 1'b1, 2'b00, 16, 64'h8000, 32, 64'hDF2C_0000, -1);
      ready_mode = 1;
      @(posedge Clock);
      #1;

      // Frame_Start while a pair sits in EMIT_A: pending bits dropped
      ready_mode = 0;
      @(posedge Clock);
      #1;
      pulse_frame_start(2'b00);
      in_if.valid = 1'b1;
      in_if.data  = 1'b1;
      @(negedge Clock);
      check("mid_fs_accept", 32'(in_if.ready), 32'd1);
      @(posedge Clock);
      #1;
      in_if.valid = 1'b0;
      in_if.data  = 1'b0;
      @(negedge Clock);
      check("mid_fs_emit_a_valid", 32'(out_if.valid), 32'd1);
      check("mid_fs_emit_a_bit", 32'(out_if.data), 32'd1);
      @(posedge Clock);
      #1;
      ready_mode = 1;
      pulse_frame_start(2'b10);
      @(negedge Clock);
      check("mid_fs_idle_after", 32'(out_if.valid), 32'd0);
      @(posedge Clock);
      #1;
      run_frame("mid_fs_r34", 1'b0, 2'b10, 12, 64'b1000_0000_0000, 16, 64'b1101_1100_1100_0000, 15);

      // Reset mid-frame: outputs return to reset values at once
      ready_mode = 0;
      @(posedge Clock);
      #1;
      pulse_frame_start(2'b00);
      in_if.valid = 1'b1;
      in_if.data  = 1'b1;
      @(posedge Clock);
      #1;
      in_if.valid = 1'b0;
      in_if.data  = 1'b0;
      @(negedge Clock);
      check("mid_rst_pre_valid", 32'(out_if.valid), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_if.valid), 32'd0);
      check("mid_rst_output", 32'(out_if.data), 32'd0);
      check("mid_rst_in_ready", 32'(in_if.ready), 32'd1);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      ready_mode = 1;
      @(posedge Clock);
      #1;
      run_frame("post_rst_r12", 1'b1, 2'b00, 8, 64'b1000_0000, 16, 64'b1101_1111_0010_1100, 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
